hex_7seg_scanner: RTL and testbench
===================================

# hex_7seg_scanner

Time-multiplexed hexadecimal display driver for NUM_DIGITS common-enable seven-segment digits. It is the parametrised successor of the single-digit combinational decoder. It latches a multi-nibble value through a load/commit path that prevents tearing, scans the digits round-robin with an anti-ghosting gap, and can blank leading zeros and blink the whole display. It sits between the board's control logic and the display pins.

## Interface
- NUM_DIGITS, 2: number of digits scanned; must be ≥1.
- CLKS_PER_DIGIT, 25000: clocks per digit slot; must be ≥2.
- BLINK_CLKS, 12500000: clocks per blink half-period; must be ≥1.
- ACTIVE_LOW, 1: 1 means segment and digit-enable outputs are active low; 0 means active high.
- BLANK_LEADING_ZEROS, 1: 1 enables suppression of leading zero digits.

Ports:
- i_Clk  in  1  the block's single clock.
- i_Rst_L  in  1  reset; synchronous and active-low.
- i_Load  in  1  single-cycle strobe; captures i_Value into the shadow register.
- i_Value  in  4*NUM_DIGITS  value to display; nibble k drives digit k, and nibble 0 is the rightmost digit.
- i_Blink_En  in  1  level; enables blinking.
- o_Segments  out  7  bit order {G,F,E,D,C,B,A}, polarity set by ACTIVE_LOW.
- o_Digit_En  out  NUM_DIGITS  one-hot-or-zero digit select, polarity set by ACTIVE_LOW.
- o_Pending  out  1  high while a loaded value waits for commit.

## Operation
- Decode in positive logic, {G..A} hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Outputs are inverted when ACTIVE_LOW=1.
- State registers:
  - r_Shadow and r_Display, each 4*NUM_DIGITS wide.
  - r_Count, 0..CLKS_PER_DIGIT-1.
  - r_Digit, 0..NUM_DIGITS-1.
  - r_Blink_Cnt, 0..BLINK_CLKS-1.
  - r_Blink_Off.
  - r_Pending.
- Scan:
  - r_Count increments every clock.
  - When r_Count = CLKS_PER_DIGIT-1, r_Count goes to 0 and r_Digit advances.
  - r_Digit wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the edge where r_Digit wraps to 0. When NUM_DIGITS=1, every slot end is a frame boundary.
- Load: i_Load=1 writes i_Value to r_Shadow and sets r_Pending. If several loads occur before commit, the last one wins.
- Commit: at a frame boundary with r_Pending=1, r_Display takes r_Shadow and r_Pending clears.
- Load at a frame boundary: i_Value commits directly to r_Display, and r_Pending stays or returns to 0.
- Anti-ghosting gap: while r_Count = 0, all digit enables are inactive.
- Leading-zero blank, applied when BLANK_LEADING_ZEROS=1: digit k>0 is blanked (segments off, enable still driven) if nibbles k..NUM_DIGITS-1 of r_Display are all zero. Digit 0 is never blanked.
- Blink, while i_Blink_En=1:
  - r_Blink_Cnt counts; at BLINK_CLKS-1 it wraps and r_Blink_Off toggles.
  - While r_Blink_Off=1, all segments are off and the scan continues.
- Blink disabled (i_Blink_En=0): r_Blink_Cnt=0 and r_Blink_Off=0, so the next enable starts with an on phase.

## Timing
- Outputs are registered, one-cycle latency: o_Segments and o_Digit_En at edge n+1 reflect r_Digit, r_Count, r_Display and r_Blink_Off after edge n.
- Reset with i_Rst_L=0 sampled at an edge:
  - All state clears: registers 0, r_Digit=0.
  - o_Segments becomes all-off (7'h7F when ACTIVE_LOW=1, 7'h00 otherwise).
  - o_Digit_En becomes all inactive.
  - o_Pending becomes 0.
- Reset mid-scan or mid-pending: a pending value is discarded.
- First enable after reset release:
  - Digit 0 enable asserts at output edge 2: state r_Count=1 after edge 1, registered at edge 2.
  - It stays asserted for CLKS_PER_DIGIT-1 cycles per slot.
- Slot length is CLKS_PER_DIGIT; frame length is NUM_DIGITS*CLKS_PER_DIGIT.
- Load-to-visible latency runs to the next frame boundary plus one cycle. The worst case is NUM_DIGITS*CLKS_PER_DIGIT+1.
- o_Pending rises the edge after i_Load and falls on the commit edge.
- i_Load and reset asserted together: reset wins.

## Test plan
Bench settings: NUM_DIGITS=2, CLKS_PER_DIGIT=4, BLINK_CLKS=8, ACTIVE_LOW=1.
- Reset: hold i_Rst_L=0 for 3 clocks -> o_Segments=7'h7F, o_Digit_En=2'b11, o_Pending=0. After release: o_Digit_En=2'b10 for 3 cycles starting at edge 2, gap 2'b11 for 1 cycle, then 2'b01 for 3 cycles.
- Decode sweep: load each 8'h00..8'hFF. After commit, each digit shows ~pattern (for example nibble A gives o_Segments=~7'h77=7'h08), and digit 1 shows the high nibble.
- Tear-free commit: load 8'h12 mid-slot of digit 0 -> o_Pending=1, and old digits persist until the wrap. Loads 8'h34 then 8'h56 before the wrap -> 8'h56 is committed and o_Pending=0.
- Load exactly on a frame boundary: i_Value=8'h9A -> r_Display=8'h9A immediately and o_Pending stays 0.
- Leading zeros: load 8'h05 -> digit 1 segments 7'h7F while its enable is active; digit 0 shows ~7'h6D. Load 8'h00 -> digit 0 shows ~7'h3F.
- Blink: i_Blink_En=1 -> segments on for 8 clocks, then all-off for 8 clocks, repeating while the scan continues. Deassert, then reassert -> the cycle restarts with the on phase. Reset mid-blink -> everything clears.

Source files
------------

// File: rtl/hex_7seg_scanner.sv
// Multiplexed hex display driver: tear-free load/commit of a multi-nibble
// value, round-robin digit scan with a dark gap at each slot start,
// optional leading-zero blanking and whole-display blink.
module hex_7seg_scanner #(
  parameter int NUM_DIGITS          = 2,
  parameter int CLKS_PER_DIGIT      = 25000,
  parameter int BLINK_CLKS          = 12500000,
  parameter int ACTIVE_LOW          = 1,
  parameter int BLANK_LEADING_ZEROS = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Blink_En,
  output logic [6:0]              o_Segments,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Pending
);

  localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CLKS - 1);

  // XOR masks that turn positive-logic values into pin polarity; they
  // double as the "everything off" pin values.
  localparam logic                  POL     = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{POL}};

  logic [4*NUM_DIGITS-1:0] r_Shadow;
  logic [4*NUM_DIGITS-1:0] r_Display;
  logic [CNT_W-1:0]        r_Count;
  logic [DIG_W-1:0]        r_Digit;
  logic [BLK_W-1:0]        r_Blink_Cnt;
  logic                    r_Blink_Off;
  logic                    r_Pending;
  logic [6:0]              r_Segments;
  logic [NUM_DIGITS-1:0]   r_Digit_En;

  logic                    w_Slot_End;
  logic                    w_Frame_End;
  logic [NUM_DIGITS-1:0]   w_Blank;
  logic [6:0]              w_Seg_Pos;
  logic [NUM_DIGITS-1:0]   w_En_Pos;

  // Positive-logic {G,F,E,D,C,B,A} hex glyphs.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 7'h3F;
      4'h1:    f_decode = 7'h06;
      4'h2:    f_decode = 7'h5B;
      4'h3:    f_decode = 7'h4F;
      4'h4:    f_decode = 7'h66;
      4'h5:    f_decode = 7'h6D;
      4'h6:    f_decode = 7'h7D;
      4'h7:    f_decode = 7'h07;
      4'h8:    f_decode = 7'h7F;
      4'h9:    f_decode = 7'h6F;
      4'hA:    f_decode = 7'h77;
      4'hB:    f_decode = 7'h7C;
      4'hC:    f_decode = 7'h39;
      4'hD:    f_decode = 7'h5E;
      4'hE:    f_decode = 7'h79;
      default: f_decode = 7'h71;
    endcase
  endfunction

  assign w_Slot_End  = (r_Count == CNT_LAST);
  assign w_Frame_End = w_Slot_End && (r_Digit == DIG_LAST);

  // Slot timer and round-robin digit pointer.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
      r_Digit <= '0;
    end else if (w_Slot_End) begin
      r_Count <= '0;
      r_Digit <= (r_Digit == DIG_LAST) ? '0 : r_Digit + DIG_W'(1);
    end else begin
      r_Count <= r_Count + CNT_W'(1);
    end
  end

  // Shadow/display pair: loads wait in the shadow and only reach the
  // display at a frame boundary, so a frame never mixes old and new digits.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Shadow  <= '0;
      r_Display <= '0;
      r_Pending <= 1'b0;
    end else if (i_Load && w_Frame_End) begin
      r_Shadow  <= i_Value;
      r_Display <= i_Value;
      r_Pending <= 1'b0;
    end else if (i_Load) begin
      r_Shadow  <= i_Value;
      r_Pending <= 1'b1;
    end else if (w_Frame_End && r_Pending) begin
      r_Display <= r_Shadow;
      r_Pending <= 1'b0;
    end
  end

  // Blink phase timer; held cleared while disabled so enabling starts lit.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || !i_Blink_En) begin
      r_Blink_Cnt <= '0;
      r_Blink_Off <= 1'b0;
    end else if (r_Blink_Cnt == BLK_LAST) begin
      r_Blink_Cnt <= '0;
      r_Blink_Off <= ~r_Blink_Off;
    end else begin
      r_Blink_Cnt <= r_Blink_Cnt + BLK_W'(1);
    end
  end

  // Digit k>0 is blank when it and every more-significant nibble are zero.
  always_comb begin : lz_blank
    logic v_zero_run;
    v_zero_run = 1'b1;
    w_Blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_run = v_zero_run && (r_Display[4*k +: 4] == 4'h0);
      w_Blank[k] = v_zero_run && (BLANK_LEADING_ZEROS != 0);
    end
  end

  // Positive-logic segment and enable values for the current slot.
  always_comb begin
    w_Seg_Pos = f_decode(r_Display[4*r_Digit +: 4]);
    if (w_Blank[r_Digit] || r_Blink_Off) begin
      w_Seg_Pos = 7'h00;
    end
    w_En_Pos = '0;
    if (r_Count != '0) begin
      w_En_Pos[r_Digit] = 1'b1;
    end
  end

  // Output registers with pin polarity applied.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Segments <= SEG_OFF;
      r_Digit_En <= EN_OFF;
    end else begin
      r_Segments <= w_Seg_Pos ^ SEG_OFF;
      r_Digit_En <= w_En_Pos ^ EN_OFF;
    end
  end

  assign o_Segments = r_Segments;
  assign o_Digit_En = r_Digit_En;
  assign o_Pending  = r_Pending;

endmodule

// File: tb/tb_hex_7seg_scanner.sv
// Directed bench for hex_7seg_scanner (2 digits, 4 clocks/slot, blink 8).
module tb_hex_7seg_scanner;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Load = 1'b0;
  logic [7:0] i_Value = 8'h00;
  logic       i_Blink_En = 1'b0;
  logic [6:0] o_Segments;
  logic [1:0] o_Digit_En;
  logic       o_Pending;

  hex_7seg_scanner #(
    .NUM_DIGITS(2), .CLKS_PER_DIGIT(4), .BLINK_CLKS(8),
    .ACTIVE_LOW(1), .BLANK_LEADING_ZEROS(1)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Load(i_Load), .i_Value(i_Value),
    .i_Blink_En(i_Blink_En), .o_Segments(o_Segments),
    .o_Digit_En(o_Digit_En), .o_Pending(o_Pending)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct { logic [3:0] nib; logic [6:0] pat; } dec_t;
  typedef struct { logic [7:0] value; logic [6:0] seg0; logic [6:0] seg1; } vec_t;

  dec_t dec_tab[16];
  vec_t vecs[7];
  int   total = 0;
  int   bad = 0;
  int   e = 0;   // rising edges since reset release

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", nm, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    e++;
    @(negedge i_Clk);
  endtask

  task automatic advance_to(input int m);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (e % 8 == m) break;
    end
  endtask

  task automatic load(input logic [7:0] v);
    i_Load  = 1'b1;
    i_Value = v;
    tick();
    i_Load  = 1'b0;
  endtask

  function automatic logic [6:0] lookup(input logic [3:0] n);
    logic [6:0] p;
    p = 7'h00;
    for (int k = 0; k < 16; k++) if (dec_tab[k].nib == n) p = dec_tab[k].pat;
    return p;
  endfunction

  // Enable pattern at output edge ee (reflects scan state after edge ee-1).
  function automatic logic [1:0] exp_en(input int ee);
    int m;
    m = ee % 8;
    if (m == 1 || m == 5) return 2'b11;
    if (m >= 2 && m <= 4) return 2'b10;
    return 2'b01;
  endfunction

  task automatic check_frame(input string nm, input logic [6:0] s0, input logic [6:0] s1);
    advance_to(2);
    chk({nm, "_en0"}, o_Digit_En, 2'b10);
    chk({nm, "_seg0"}, o_Segments, s0);
    advance_to(6);
    chk({nm, "_en1"}, o_Digit_En, 2'b01);
    chk({nm, "_seg1"}, o_Segments, s1);
  endtask

  // Runs n edges checking enables, pending=0 and segments in active slots;
  // with blink set, outputs are dark during odd 8-edge windows from edge b0.
  task automatic scan_check(input string nm, input int n, input logic [6:0] s0,
                            input logic [6:0] s1, input logic blink, input int b0);
    int  m;
    logic off;
    for (int k = 0; k < n; k++) begin
      tick();
      m   = e % 8;
      off = blink && ((((e - b0) / 8) % 2) == 1);
      chk({nm, "_en"}, o_Digit_En, exp_en(e));
      chk({nm, "_pend"}, o_Pending, 1'b0);
      if (m != 1 && m != 5)
        chk({nm, "_seg"}, o_Segments, off ? 7'h7F : ((m >= 2 && m <= 4) ? s0 : s1));
    end
  endtask

  initial begin
    logic [6:0] x0, x1;
    int b0;

    dec_tab = '{'{4'h0, 7'h3F}, '{4'h1, 7'h06}, '{4'h2, 7'h5B}, '{4'h3, 7'h4F},
                '{4'h4, 7'h66}, '{4'h5, 7'h6D}, '{4'h6, 7'h7D}, '{4'h7, 7'h07},
                '{4'h8, 7'h7F}, '{4'h9, 7'h6F}, '{4'hA, 7'h77}, '{4'hB, 7'h7C},
                '{4'hC, 7'h39}, '{4'hD, 7'h5E}, '{4'hE, 7'h79}, '{4'hF, 7'h71}};
    // Active-low pin values, hand computed; digit 1 blank when its nibble is 0.
    vecs = '{'{8'h00, 7'h40, 7'h7F}, '{8'h05, 7'h12, 7'h7F},
             '{8'h9A, 7'h08, 7'h10}, '{8'h10, 7'h40, 7'h79},
             '{8'hA0, 7'h40, 7'h08}, '{8'hFF, 7'h0E, 7'h0E},
             '{8'h3C, 7'h46, 7'h30}};

    // Reset held for three clocks.
    i_Rst_L = 1'b0;
    repeat (3) tick();
    chk("rst_seg", o_Segments, 7'h7F);
    chk("rst_en", o_Digit_En, 2'b11);
    chk("rst_pend", o_Pending, 1'b0);
    i_Rst_L = 1'b1;
    e = 0;

    // First frame after release: gap, digit 0 x3, gap, digit 1 x3.
    scan_check("post_rst", 8, 7'h40, 7'h7F, 1'b0, 0);

    // Decode sweep over every byte value.
    for (int v = 0; v < 256; v++) begin
      advance_to(2);
      load(8'(v));
      chk("sweep_pend", o_Pending, 1'b1);
      x0 = ~lookup(4'(v));
      x1 = ((v >> 4) == 0) ? 7'h7F : ~lookup(4'(v >> 4));
      check_frame("sweep", x0, x1);
    end

    // Tear-free commit: display holds FF while 12, 34, 56 are loaded.
    advance_to(2);
    load(8'h12);
    chk("tear_pend_a", o_Pending, 1'b1);
    chk("tear_old0", o_Segments, 7'h0E);
    chk("tear_en0", o_Digit_En, 2'b10);
    load(8'h34);
    load(8'h56);
    advance_to(6);
    chk("tear_old1", o_Segments, 7'h0E);
    chk("tear_pend_b", o_Pending, 1'b1);
    advance_to(7);
    chk("tear_pend_c", o_Pending, 1'b1);
    tick();
    chk("tear_commit_pend", o_Pending, 1'b0);
    chk("tear_last_old1", o_Segments, 7'h0E);
    check_frame("tear_new", 7'h02, 7'h12);

    // Load landing exactly on the frame boundary commits at once.
    advance_to(7);
    load(8'h9A);
    chk("bound_edge", e % 8, 0);
    chk("bound_pend", o_Pending, 1'b0);
    check_frame("bound", 7'h08, 7'h10);

    // Hand-computed vectors including leading-zero cases.
    foreach (vecs[i]) begin
      advance_to(2);
      load(vecs[i].value);
      check_frame("vec", vecs[i].seg0, vecs[i].seg1);
    end

    // Blink: 8 lit, 8 dark, repeating; scan keeps running.
    advance_to(2);
    load(8'h88);
    check_frame("blink_pre", 7'h00, 7'h00);
    i_Blink_En = 1'b1;
    b0 = e + 1;
    scan_check("blink", 32, 7'h00, 7'h00, 1'b1, b0);
    scan_check("blink_b", 12, 7'h00, 7'h00, 1'b1, b0);
    // Now in a dark phase; disabling relights on the following edge.
    i_Blink_En = 1'b0;
    tick();
    scan_check("blink_dis", 4, 7'h00, 7'h00, 1'b0, 0);
    i_Blink_En = 1'b1;
    b0 = e + 1;
    scan_check("blink_re", 12, 7'h00, 7'h00, 1'b1, b0);

    // Reset mid-blink and mid-pending, with a coincident load.
    advance_to(2);
    load(8'h77);
    chk("rb_pend", o_Pending, 1'b1);
    i_Rst_L = 1'b0;
    i_Load  = 1'b1;
    i_Value = 8'h12;
    tick();
    chk("rb_seg", o_Segments, 7'h7F);
    chk("rb_en", o_Digit_En, 2'b11);
    chk("rb_pend0", o_Pending, 1'b0);
    i_Load = 1'b0;
    repeat (2) tick();
    i_Rst_L = 1'b1;
    e = 0;
    scan_check("rb_after", 24, 7'h40, 7'h7F, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
